// File: rtl/risc_pkg.sv
// Shared IITB-RISC decode constants: LM/SM opcodes, LMStart codes and
// the LM/SM sequencer state type.
package risc_pkg;

    localparam logic [3:0] OP_LM = 4'b0110;
    localparam logic [3:0] OP_SM = 4'b0111;

    localparam logic [1:0] LMS_NONE  = 2'b00;
    localparam logic [1:0] LMS_FIRST = 2'b01;
    localparam logic [1:0] LMS_MID   = 2'b10;
    localparam logic [1:0] LMS_LAST  = 2'b11;

    typedef enum logic {
        IDLE = 1'b0,
        SEQ  = 1'b1
    } seq_state_t;

endpackage

// File: rtl/lsb_enc8.sv
// Lowest-set-bit encoder for an 8-bit register mask.
// Ports: mask in; idx = index of lowest set bit, any = mask nonzero,
// one = exactly one bit set.
module lsb_enc8 (
    input  logic [7:0] mask,
    output logic [2:0] idx,
    output logic       any,
    output logic       one
);

    always_comb begin
        idx = 3'd0;
        for (int i = 7; i >= 0; i--) begin
            if (mask[i]) idx = i[2:0];
        end
    end

    assign any = |mask;
    // clearing the lowest set bit leaves zero only for a single bit
    assign one = any && ((mask & (mask - 8'd1)) == 8'd0);

endmodule

// File: rtl/id_lmsm_seq.sv
// Decode-stage LM/SM micro-sequencer: expands load/store-multiple into
// one register micro-op per mask bit, stalling fetch while it runs.
// Ports: clk (negedge active), reset (async high), IF/ID inputs
// in_valid/in_pc/in_IW, stall_ID, flush; micro-op outputs out_* and
// stall_IF back to fetch.
module id_lmsm_seq
    import risc_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        in_valid,
    input  logic [15:0] in_pc,
    input  logic [15:0] in_IW,
    input  logic        stall_ID,
    input  logic        flush,
    output logic        out_valid,
    output logic [15:0] out_pc,
    output logic [15:0] out_IW,
    output logic        out_lmsm,
    output logic [2:0]  out_RDest,
    output logic [15:0] out_imm,
    output logic [1:0]  out_LMStart,
    output logic        out_W_reg,
    output logic        out_W_mem,
    output logic        out_mem_ans,
    output logic        stall_IF
);

    seq_state_t  state_q, state_d;
    logic [7:0]  mask_q, mask_d;
    logic [2:0]  off_q, off_d;
    logic [15:0] iw_q, iw_d;
    logic [15:0] pc_q, pc_d;
    logic        is_sm_q, is_sm_d;

    logic [3:0]  opc;
    logic        is_seq;
    logic        idle_lmsm;
    logic        cur_sm;
    logic        uop;
    logic [7:0]  enc_in;
    logic [2:0]  enc_idx;
    logic        enc_any;
    logic        enc_one;

    assign opc       = in_IW[15:12];
    assign is_seq    = (state_q == SEQ);
    assign idle_lmsm = in_valid && (opc == OP_LM || opc == OP_SM);
    assign enc_in    = is_seq ? mask_q : in_IW[7:0];
    assign cur_sm    = is_seq ? is_sm_q : (opc == OP_SM);
    assign uop       = is_seq || (idle_lmsm && enc_any);

    lsb_enc8 u_enc (
        .mask (enc_in),
        .idx  (enc_idx),
        .any  (enc_any),
        .one  (enc_one)
    );

    always_ff @(negedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            mask_q  <= 8'd0;
            off_q   <= 3'd0;
            iw_q    <= 16'd0;
            pc_q    <= 16'd0;
            is_sm_q <= 1'b0;
        end else begin
            state_q <= state_d;
            mask_q  <= mask_d;
            off_q   <= off_d;
            iw_q    <= iw_d;
            pc_q    <= pc_d;
            is_sm_q <= is_sm_d;
        end
    end

    always_comb begin
        state_d = state_q;
        mask_d  = mask_q;
        off_d   = off_q;
        iw_d    = iw_q;
        pc_d    = pc_q;
        is_sm_d = is_sm_q;
        if (flush) begin
            state_d = IDLE;
            mask_d  = 8'd0;
            off_d   = 3'd0;
        end else if (!stall_ID) begin
            if (uop && !enc_one) begin
                state_d = SEQ;
                mask_d  = enc_in & (enc_in - 8'd1);
                off_d   = is_seq ? off_q + 3'd1 : 3'd1;
                if (!is_seq) begin
                    iw_d    = in_IW;
                    pc_d    = in_pc;
                    is_sm_d = (opc == OP_SM);
                end
            end else if (is_seq) begin
                state_d = IDLE;
                mask_d  = 8'd0;
                off_d   = 3'd0;
            end
        end
    end

    always_comb begin
        out_valid   = 1'b0;
        out_pc      = 16'd0;
        out_IW      = 16'd0;
        out_lmsm    = 1'b0;
        out_RDest   = 3'd0;
        out_imm     = 16'd0;
        out_LMStart = LMS_NONE;
        out_W_reg   = 1'b0;
        out_W_mem   = 1'b0;
        out_mem_ans = 1'b0;
        stall_IF    = 1'b0;
        if (!reset) begin
            out_pc    = is_seq ? pc_q : in_pc;
            out_IW    = is_seq ? iw_q : in_IW;
            out_valid = is_seq ? 1'b1
                      : (idle_lmsm ? enc_any : in_valid);
            if (uop) begin
                out_lmsm  = 1'b1;
                out_RDest = enc_idx;
                out_imm   = {13'd0, is_seq ? off_q : 3'd0};
                if (enc_one) out_LMStart = LMS_LAST;
                else if (is_seq) out_LMStart = LMS_MID;
                else out_LMStart = LMS_FIRST;
                out_W_reg   = !cur_sm;
                out_mem_ans = !cur_sm;
                out_W_mem   = cur_sm;
                stall_IF    = !enc_one;
            end
            // a killed micro-op must not write anything downstream
            if (flush) begin
                out_valid   = 1'b0;
                out_W_reg   = 1'b0;
                out_W_mem   = 1'b0;
                out_mem_ans = 1'b0;
                stall_IF    = 1'b0;
            end else if (stall_ID) begin
                stall_IF = 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_id_lmsm_seq.sv
// Directed bench for the LM/SM decode micro-sequencer.
// Drives inputs just after each falling edge and checks mid-cycle.
module tb_id_lmsm_seq;

    logic        clk = 1'b0;
    logic        reset;
    logic        in_valid;
    logic [15:0] in_pc;
    logic [15:0] in_IW;
    logic        stall_ID;
    logic        flush;
    logic        out_valid;
    logic [15:0] out_pc;
    logic [15:0] out_IW;
    logic        out_lmsm;
    logic [2:0]  out_RDest;
    logic [15:0] out_imm;
    logic [1:0]  out_LMStart;
    logic        out_W_reg;
    logic        out_W_mem;
    logic        out_mem_ans;
    logic        stall_IF;

    int n_pass = 0;
    int n_total = 0;
    int n_uops;

    always #5 clk = ~clk;

    id_lmsm_seq dut (
        .clk         (clk),
        .reset       (reset),
        .in_valid    (in_valid),
        .in_pc       (in_pc),
        .in_IW       (in_IW),
        .stall_ID    (stall_ID),
        .flush       (flush),
        .out_valid   (out_valid),
        .out_pc      (out_pc),
        .out_IW      (out_IW),
        .out_lmsm    (out_lmsm),
        .out_RDest   (out_RDest),
        .out_imm     (out_imm),
        .out_LMStart (out_LMStart),
        .out_W_reg   (out_W_reg),
        .out_W_mem   (out_W_mem),
        .out_mem_ans (out_mem_ans),
        .stall_IF    (stall_IF)
    );

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    task automatic drive(input logic v, input logic [15:0] pc,
                         input logic [15:0] iw, input logic st,
                         input logic fl);
        in_valid = v;
        in_pc    = pc;
        in_IW    = iw;
        stall_ID = st;
        flush    = fl;
        #2;
    endtask

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic chk_uop(input string tag, input logic [2:0] rd,
                           input logic [2:0] imm, input logic [1:0] lms,
                           input logic sm, input logic stl);
        chk({tag, ".valid"}, 32'(out_valid), 32'd1);
        chk({tag, ".lmsm"}, 32'(out_lmsm), 32'd1);
        chk({tag, ".rdest"}, 32'(out_RDest), 32'(rd));
        chk({tag, ".imm"}, 32'(out_imm), 32'(imm));
        chk({tag, ".lmstart"}, 32'(out_LMStart), 32'(lms));
        chk({tag, ".wreg"}, 32'(out_W_reg), 32'(!sm));
        chk({tag, ".memans"}, 32'(out_mem_ans), 32'(!sm));
        chk({tag, ".wmem"}, 32'(out_W_mem), 32'(sm));
        chk({tag, ".stallif"}, 32'(stall_IF), 32'(stl));
    endtask

    initial begin
        reset = 1'b1;
        drive(1'b1, 16'h0004, 16'h0123, 1'b0, 1'b0);
        chk("rst.valid", 32'(out_valid), 32'd0);
        chk("rst.iw", 32'(out_IW), 32'd0);
        chk("rst.stallif", 32'(stall_IF), 32'd0);
        tick();
        reset = 1'b0;

        // plain ADD passes through
        drive(1'b1, 16'h0010, 16'h0ABC, 1'b0, 1'b0);
        chk("add.valid", 32'(out_valid), 32'd1);
        chk("add.lmsm", 32'(out_lmsm), 32'd0);
        chk("add.iw", 32'(out_IW), 32'h0ABC);
        chk("add.pc", 32'(out_pc), 32'h0010);
        chk("add.lmstart", 32'(out_LMStart), 32'd0);
        chk("add.stallif", 32'(stall_IF), 32'd0);
        tick();

        // LM mask A5 -> R0,R2,R5,R7
        drive(1'b1, 16'h0020, 16'h60A5, 1'b0, 1'b0);
        chk_uop("lm0", 3'd0, 3'd0, 2'b01, 1'b0, 1'b1);
        tick();
        drive(1'b1, 16'h0020, 16'h60A5, 1'b0, 1'b0);
        chk_uop("lm1", 3'd2, 3'd1, 2'b10, 1'b0, 1'b1);
        chk("lm1.pc", 32'(out_pc), 32'h0020);
        chk("lm1.iw", 32'(out_IW), 32'h60A5);
        tick();
        drive(1'b0, 16'h0022, 16'h0F0F, 1'b0, 1'b0);
        chk_uop("lm2", 3'd5, 3'd2, 2'b10, 1'b0, 1'b1);
        tick();
        drive(1'b0, 16'h0022, 16'h0F0F, 1'b0, 1'b0);
        chk_uop("lm3", 3'd7, 3'd3, 2'b11, 1'b0, 1'b0);
        chk("lm3.iw", 32'(out_IW), 32'h60A5);
        tick();

        // single-bit SM
        drive(1'b1, 16'h0030, 16'h7010, 1'b0, 1'b0);
        chk_uop("sm1", 3'd4, 3'd0, 2'b11, 1'b1, 1'b0);
        tick();

        // LM with empty mask is a NOP
        drive(1'b1, 16'h0032, 16'h6000, 1'b0, 1'b0);
        chk("lm0m.valid", 32'(out_valid), 32'd0);
        chk("lm0m.stallif", 32'(stall_IF), 32'd0);
        tick();
        drive(1'b1, 16'h0034, 16'h1234, 1'b0, 1'b0);
        chk("lm0m.next", 32'(out_IW), 32'h1234);
        chk("lm0m.nextlmsm", 32'(out_lmsm), 32'd0);
        tick();

        // SM FF with stall_ID held on the third micro-op
        n_uops = 0;
        drive(1'b1, 16'h0040, 16'h70FF, 1'b0, 1'b0);
        chk_uop("smff0", 3'd0, 3'd0, 2'b01, 1'b1, 1'b1);
        n_uops += int'(out_valid);
        tick();
        drive(1'b1, 16'h0040, 16'h70FF, 1'b0, 1'b0);
        chk_uop("smff1", 3'd1, 3'd1, 2'b10, 1'b1, 1'b1);
        n_uops += int'(out_valid);
        tick();
        for (int k = 0; k < 2; k++) begin
            drive(1'b1, 16'h0040, 16'h70FF, 1'b1, 1'b0);
            chk_uop("smffhold", 3'd2, 3'd2, 2'b10, 1'b1, 1'b1);
            tick();
        end
        for (int r = 2; r < 8; r++) begin
            drive(1'b1, 16'h0040, 16'h70FF, 1'b0, 1'b0);
            chk_uop("smffrun", 3'(r), 3'(r),
                    (r == 7) ? 2'b11 : 2'b10, 1'b1, (r != 7));
            n_uops += int'(out_valid);
            tick();
        end
        chk("smff.count", 32'(n_uops), 32'd8);

        // LM F0 flushed on its second micro-op
        drive(1'b1, 16'h0050, 16'h60F0, 1'b0, 1'b0);
        chk_uop("lmf0", 3'd4, 3'd0, 2'b01, 1'b0, 1'b1);
        tick();
        drive(1'b1, 16'h0050, 16'h60F0, 1'b0, 1'b1);
        chk("flush.valid", 32'(out_valid), 32'd0);
        chk("flush.stallif", 32'(stall_IF), 32'd0);
        tick();
        drive(1'b1, 16'h0060, 16'h1234, 1'b0, 1'b0);
        chk("flushnext.valid", 32'(out_valid), 32'd1);
        chk("flushnext.iw", 32'(out_IW), 32'h1234);
        chk("flushnext.pc", 32'(out_pc), 32'h0060);
        chk("flushnext.lmsm", 32'(out_lmsm), 32'd0);
        chk("flushnext.stallif", 32'(stall_IF), 32'd0);
        tick();

        // reset mid-sequence on LM FF
        drive(1'b1, 16'h0070, 16'h60FF, 1'b0, 1'b0);
        chk_uop("lmff0", 3'd0, 3'd0, 2'b01, 1'b0, 1'b1);
        tick();
        drive(1'b1, 16'h0070, 16'h60FF, 1'b0, 1'b0);
        chk_uop("lmff1", 3'd1, 3'd1, 2'b10, 1'b0, 1'b1);
        #1;
        reset = 1'b1;
        #1;
        chk("midrst.valid", 32'(out_valid), 32'd0);
        chk("midrst.lmsm", 32'(out_lmsm), 32'd0);
        chk("midrst.wreg", 32'(out_W_reg), 32'd0);
        chk("midrst.lmstart", 32'(out_LMStart), 32'd0);
        chk("midrst.iw", 32'(out_IW), 32'd0);
        chk("midrst.stallif", 32'(stall_IF), 32'd0);
        tick();
        reset = 1'b0;
        drive(1'b1, 16'h0080, 16'h0456, 1'b0, 1'b0);
        chk("postrst.valid", 32'(out_valid), 32'd1);
        chk("postrst.iw", 32'(out_IW), 32'h0456);
        chk("postrst.lmsm", 32'(out_lmsm), 32'd0);
        chk("postrst.stallif", 32'(stall_IF), 32'd0);
        tick();

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
